// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with single-outstanding imem requests and a prefetch queue
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          PC_STEP  = 4,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcOut,
  output logic [31:0] instr,
  output logic        if_valid,
  output logic        pipe_write,
  output logic        pipe_flush
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = CW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} stateT;

  stateT          state, stateNext;
  logic [31:0]    fetchPc;
  logic [AW-1:0]  headPtr, tailPtr;
  logic [CW-1:0]  count;
  logic [31:0]    qPc    [DEPTH];
  logic [31:0]    qInstr [DEPTH];

  logic           push, pop, room, canIssue;
  logic [FW-1:0]  fillNext;

  // reset gates every output so nothing stale leaks out before the first edge
  assign if_valid   = reset && (count != '0);
  assign pop        = if_valid && !stall && !redirect;
  assign push       = reset && imem_ack && (state == WAIT) && !redirect;

  // one slot is reserved for the response of the request issued this cycle
  assign fillNext   = {1'b0, count} + FW'(push) + FW'(1'b1) - FW'(pop);
  assign room       = (fillNext <= FW'(DEPTH));
  assign canIssue   = (state == IDLE) || ((state == WAIT) && imem_ack);

  assign imem_req   = reset && !redirect && room && canIssue;
  assign imem_addr  = fetchPc;
  assign pcOut      = if_valid ? qPc[headPtr] : 32'h0;
  assign instr      = if_valid ? qInstr[headPtr] : 32'h0;
  assign pipe_write = !stall || !reset;
  assign pipe_flush = redirect || !reset;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (imem_req) stateNext = WAIT;
      end
      WAIT: begin
        if (redirect)      stateNext = imem_ack ? IDLE : DROP;
        else if (imem_ack) stateNext = imem_req ? WAIT : IDLE;
      end
      DROP: begin
        if (imem_ack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      headPtr <= '0;
      tailPtr <= '0;
      fetchPc <= PC_RESET;
    end else begin
      state <= stateNext;
      if (redirect) begin
        count   <= '0;
        headPtr <= '0;
        tailPtr <= '0;
        fetchPc <= redirect_pc;
      end else begin
        if (imem_req) fetchPc <= fetchPc + 32'(PC_STEP);
        if (push)     tailPtr <= tailPtr + AW'(1);
        if (pop)      headPtr <= headPtr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // payload storage needs no reset; count decides what is visible
  always_ff @(posedge clk) begin
    if (push) begin
      qPc[tailPtr]    <= fetchPc - 32'(PC_STEP);
      qInstr[tailPtr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized and directed checks of fetch_stage against a queue-based model
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pcOut, instr;
  logic        if_valid, pipe_write, pipe_flush;

  logic        req2, ack2, valid2, write2, flush2, zero2;
  logic [31:0] addr2, rdata2, pcOut2, instr2, zeroPc2;

  always #5 clk = ~clk;

  fetch_stage #(.PC_RESET(32'h0000_0000), .PC_STEP(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pcOut(pcOut), .instr(instr), .if_valid(if_valid), .pipe_write(pipe_write),
    .pipe_flush(pipe_flush)
  );

  fetch_stage #(.PC_RESET(32'hFFFF_FFFC), .PC_STEP(4), .DEPTH(DEPTH)) dutWrap (
    .clk(clk), .reset(reset), .stall(zero2), .redirect(zero2), .redirect_pc(zeroPc2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .pcOut(pcOut2), .instr(instr2), .if_valid(valid2), .pipe_write(write2),
    .pipe_flush(flush2)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: in-order list of fetched {pc,instr}, next fetch pc, outstanding request status
  logic [63:0] mQ[$];
  logic [31:0] mPc, mReqPc;
  int          mOut;           // 0 none, 1 live, 2 to be discarded
  bit          memBusy;
  logic [31:0] memAddr;
  int          memCnt, memLat;
  logic        lastReq2;
  logic        obsReq, obsValid, obsFlush, obsReq2;
  logic [31:0] obsAddr, obsPc, obsInstr, obsAddr2;

  task automatic stepCycle();
    logic expReq, expValid, pushE, popE, roomE, issueE;
    logic [31:0] expPc, expInstr;
    if (!reset) begin
      memBusy = 0; imem_ack = 0; imem_rdata = $urandom;
    end else if (memBusy && memCnt == 0) begin
      imem_ack = 1; imem_rdata = memAddr + 32'h1000; memBusy = 0;
    end else begin
      imem_ack = 0; imem_rdata = $urandom;
      if (memBusy) memCnt--;
    end
    ack2 = lastReq2 & reset;
    @(negedge clk);
    if (!reset) begin
      expReq = 0; expValid = 0; expPc = 0; expInstr = 0; pushE = 0; popE = 0;
    end else begin
      expValid = mQ.size() > 0;
      expPc    = expValid ? mQ[0][63:32] : 32'h0;
      expInstr = expValid ? mQ[0][31:0]  : 32'h0;
      popE     = expValid && !stall && !redirect;
      pushE    = imem_ack && mOut == 1 && !redirect;
      roomE    = (mQ.size() + int'(pushE) - int'(popE) + 1) <= DEPTH;
      issueE   = (mOut == 0) || (mOut == 1 && imem_ack);
      expReq   = !redirect && roomE && issueE;
    end
    checkEq("imem_req", imem_req, expReq);
    if (expReq) checkEq("imem_addr", imem_addr, mPc);
    checkEq("if_valid", if_valid, expValid);
    checkEq("pcOut", pcOut, expPc);
    checkEq("instr", instr, expInstr);
    checkEq("pipe_write", pipe_write, (!reset) || !stall);
    checkEq("pipe_flush", pipe_flush, redirect || !reset);
    obsReq = imem_req; obsAddr = imem_addr; obsValid = if_valid;
    obsPc = pcOut; obsInstr = instr; obsFlush = pipe_flush;
    obsReq2 = req2; obsAddr2 = addr2;
    if (!reset) begin
      mQ.delete(); mPc = 32'h0; mOut = 0;
    end else if (redirect) begin
      mQ.delete(); mPc = redirect_pc;
      mOut = (mOut != 0 && !imem_ack) ? 2 : 0;
    end else begin
      if (popE)  void'(mQ.pop_front());
      if (pushE) mQ.push_back({mReqPc, imem_rdata});
      if (expReq) begin
        mReqPc = mPc; mPc = mPc + 32'd4; mOut = 1;
        memBusy = 1; memAddr = mReqPc; memCnt = memLat - 1;
      end else if (imem_ack) begin
        mOut = 0;
      end
    end
    lastReq2 = req2;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 0; stall = 0; redirect = 0; memLat = 1;
    repeat (3) begin
      stepCycle();
      checkEq("rst_flush", obsFlush, 1'b1);
      checkEq("rst_req", obsReq, 1'b0);
      checkEq("rst_instr", obsInstr, 32'h0);
    end
    reset = 1;
  endtask

  initial begin
    reset = 0; stall = 0; redirect = 0; redirect_pc = 0;
    imem_ack = 0; imem_rdata = 0; ack2 = 0; rdata2 = 0; zero2 = 0; zeroPc2 = 0;
    memBusy = 0; memLat = 1; memCnt = 0; memAddr = 0; lastReq2 = 0;
    mPc = 0; mReqPc = 0; mOut = 0;
    #1;

    // reset release, streaming, wrap-around on the second instance
    doReset();
    stepCycle();
    checkEq("t1_req", obsReq, 1'b1);
    checkEq("t1_addr", obsAddr, 32'h0);
    checkEq("t1_flush", obsFlush, 1'b0);
    checkEq("t1_valid", obsValid, 1'b0);
    checkEq("wrap_req0", obsReq2, 1'b1);
    checkEq("wrap_addr0", obsAddr2, 32'hFFFF_FFFC);
    stepCycle();
    checkEq("wrap_req1", obsReq2, 1'b1);
    checkEq("wrap_addr1", obsAddr2, 32'h0);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkEq("stream_valid", obsValid, 1'b1);
      checkEq("stream_pc", obsPc, 32'(4 * k));
      checkEq("stream_instr", obsInstr, 32'h1000 + 32'(4 * k));
    end

    // stall with full queue
    doReset();
    repeat (3) stepCycle();
    stall = 1;
    repeat (4) stepCycle();
    checkEq("stall_pc", obsPc, 32'h4);
    checkEq("stall_req", obsReq, 1'b0);
    stall = 0;
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkEq("unstall_pc", obsPc, 32'h4 + 32'(4 * k));
      checkEq("unstall_instr", obsInstr, 32'h1004 + 32'(4 * k));
    end

    // redirect while waiting on a slow response
    doReset();
    memLat = 3;
    stepCycle();
    memLat = 1; redirect = 1; redirect_pc = 32'h200;
    stepCycle();
    checkEq("redir_flush", obsFlush, 1'b1);
    redirect = 0;
    stepCycle();
    checkEq("redir_flush_end", obsFlush, 1'b0);
    checkEq("drop_req_a", obsReq, 1'b0);
    stepCycle();
    checkEq("drop_req_b", obsReq, 1'b0);
    checkEq("drop_valid", obsValid, 1'b0);
    stepCycle();
    checkEq("redir_req", obsReq, 1'b1);
    checkEq("redir_addr", obsAddr, 32'h200);
    repeat (2) stepCycle();
    checkEq("redir_pc", obsPc, 32'h200);
    checkEq("redir_instr", obsInstr, 32'h1200);

    // redirect coincident with ack under stall
    doReset();
    stepCycle();
    stall = 1; redirect = 1; redirect_pc = 32'h300;
    stepCycle();
    checkEq("coinc_req", obsReq, 1'b0);
    stall = 0; redirect = 0;
    stepCycle();
    checkEq("coinc_valid", obsValid, 1'b0);
    checkEq("coinc_addr", obsAddr, 32'h300);
    stepCycle();
    checkEq("coinc_valid2", obsValid, 1'b0);
    stepCycle();
    checkEq("coinc_instr", obsInstr, 32'h1300);

    // randomized traffic
    doReset();
    repeat (3000) begin
      stall       = ($urandom % 4) == 0;
      redirect    = ($urandom % 16) == 0;
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      memLat      = $urandom_range(1, 3);
      reset       = ($urandom % 200) != 0;
      stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
